// File: rtl/uart_int_ctrl.sv
// UART interrupt controller: fixed-priority arbitration of LS/RDA/CTI/THRE into a registered IIR code.
// Define UART_INT_CTI_EN to build the FIFO-mode character-timeout counters and CTI source.
module uart_int_ctrl #(
    parameter int TICKS_PER_BIT = 16,
    parameter int CTI_CHARS     = 4
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       baud_tick,
    input  logic [2:0] ier,
    input  logic       fifoen,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       rbrf,
    input  logic       rx_fifo_empty,
    input  logic       below_level,
    input  logic       tx_empty,
    input  logic       receive_done,
    input  logic       ls_event,
    input  logic       rbr_rd_en,
    input  logic       thr_wr_en,
    input  logic       iir_rd_en,
    input  logic       lsr_rd_en,
    output logic [3:0] iir,
    output logic       intr
);

    localparam logic [3:0] IIR_NONE = 4'b0001;
    localparam logic [3:0] IIR_LS   = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTI  = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;

    logic       ls_flag;
    logic       thre_flag;
    logic       cti_flag;
    logic       tx_empty_q;
    logic       etbei_q;
    logic       rda;
    logic       thre_set;
    logic       thre_clr;
    logic [3:0] iir_nxt;

    always_ff @(posedge pclk) begin
        if (!presetn)
            ls_flag <= 1'b0;
        else if (ls_event)
            ls_flag <= 1'b1;
        else if (lsr_rd_en)
            ls_flag <= 1'b0;
    end

    // THRE clear by IIR read is qualified by the code the CPU actually saw.
    assign thre_set = (tx_empty & ~tx_empty_q) | (ier[1] & ~etbei_q & tx_empty);
    assign thre_clr = thr_wr_en | (iir_rd_en & (iir == IIR_THRE));

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            thre_flag  <= 1'b0;
            tx_empty_q <= 1'b0;
            etbei_q    <= 1'b0;
        end else begin
            tx_empty_q <= tx_empty;
            etbei_q    <= ier[1];
            if (thre_clr)
                thre_flag <= 1'b0;
            else if (thre_set)
                thre_flag <= 1'b1;
        end
    end

    assign rda = fifoen ? (~rx_fifo_empty & ~below_level) : rbrf;

`ifdef UART_INT_CTI_EN
    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [5:0] CTI_C = 6'(CTI_CHARS);

    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_nxt;
    logic [5:0]    bit_cnt;
    logic [5:0]    bit_nxt;
    logic [5:0]    threshold;
    logic [3:0]    frame_bits;
    logic          cnt_clr;

    assign frame_bits = 4'd6 + {2'b00, wls} + {3'b000, pen} + (stb ? 4'd2 : 4'd1);
    assign threshold  = CTI_C * {2'b00, frame_bits};
    assign cnt_clr    = ~fifoen | rx_fifo_empty | receive_done | rbr_rd_en;

    // Counter saturates at threshold; the flag is raised on the edge it gets there.
    always_comb begin
        tick_nxt = tick_cnt;
        bit_nxt  = bit_cnt;
        if (baud_tick && (bit_cnt != threshold)) begin
            if (tick_cnt == TW'(TICKS_PER_BIT - 1)) begin
                tick_nxt = '0;
                bit_nxt  = bit_cnt + 6'd1;
            end else begin
                tick_nxt = tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn || cnt_clr) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            cti_flag <= 1'b0;
        end else begin
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            if (bit_nxt == threshold)
                cti_flag <= 1'b1;
        end
    end
`else
    logic unused_cti;
    assign cti_flag   = 1'b0;
    assign unused_cti = ^{baud_tick, wls, stb, pen, receive_done, rbr_rd_en}
                        ^ (CTI_CHARS > 0) ^ (TICKS_PER_BIT > 0);
`endif

    always_comb begin
        iir_nxt = IIR_NONE;
        if (ier[2] && ls_flag)
            iir_nxt = IIR_LS;
        else if (ier[0] && rda)
            iir_nxt = IIR_RDA;
        else if (ier[0] && cti_flag)
            iir_nxt = IIR_CTI;
        else if (ier[1] && thre_flag)
            iir_nxt = IIR_THRE;
    end

    always_ff @(posedge pclk) begin
        if (!presetn)
            iir <= IIR_NONE;
        else
            iir <= iir_nxt;
    end

    assign intr = ~iir[0];

endmodule
